// File: rtl/jump_redirect_unit_pkg.sv
// Shared definitions for the jump redirect unit: request kind encodings,
// FSM state encodings and small kind-decode helpers.
package jump_defs;

  localparam logic [2:0] KIND_J    = 3'd0;
  localparam logic [2:0] KIND_JAL  = 3'd1;
  localparam logic [2:0] KIND_JR   = 3'd2;
  localparam logic [2:0] KIND_JALR = 3'd3;
  localparam logic [2:0] KIND_BR   = 3'd4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    REDIRECT  = 2'd2
  } state_t;

  function automatic logic is_link(input logic [2:0] kind);
    return (kind == KIND_JAL) || (kind == KIND_JALR);
  endfunction

  function automatic logic is_reg_jump(input logic [2:0] kind);
    return (kind == KIND_JR) || (kind == KIND_JALR);
  endfunction

endpackage

// File: rtl/jump_redirect_unit_j_target_calc.sv
// Combinational target/taken computation for J, JAL, JR, JALR and conditional
// branches; reserved kinds yield taken=0.
module j_target_calc
  import jump_defs::*;
#(
  parameter int ADDR_W = 32,
  parameter int IMM_W  = 26
) (
  input  logic [2:0]        kind,
  input  logic [ADDR_W-1:0] pc,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] rs,
  input  logic              cmp,
  output logic [ADDR_W-1:0] target,
  output logic              taken
);

  localparam int SLOT_W = ADDR_W - IMM_W - 2;

  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] jidx_target;
  logic [ADDR_W-1:0] br_offset;

  assign pc4 = pc + ADDR_W'(4);

  // Jump index replaces everything below the region bits of the delay-slot PC.
  generate
    if (SLOT_W > 0) begin : g_region
      assign jidx_target = {pc4[ADDR_W-1 -: SLOT_W], imm, 2'b00};
    end else begin : g_noregion
      assign jidx_target = {imm, 2'b00};
    end
  endgenerate

  assign br_offset = {{(ADDR_W-18){imm[15]}}, imm[15:0], 2'b00};

  always_comb begin
    target = '0;
    taken  = 1'b0;
    case (kind)
      KIND_J, KIND_JAL: begin
        target = jidx_target;
        taken  = 1'b1;
      end
      KIND_JR, KIND_JALR: begin
        target = rs;
        taken  = 1'b1;
      end
      KIND_BR: begin
        target = pc4 + br_offset;
        taken  = cmp;
      end
      default: begin
        target = '0;
        taken  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/jump_redirect_unit.sv
// Control-transfer redirect unit: accepts one request, waits out SLOT_CNT delay
// slots, then issues a registered redirect. Optional macro: TARGET_ALIGN_CHECK_EN.
module jump_redirect_unit
  import jump_defs::*;
#(
  parameter int ADDR_W   = 32,
  parameter int IMM_W    = 26,
  parameter int SLOT_CNT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic [ADDR_W-1:0] req_pc,
  input  logic [IMM_W-1:0]  req_imm,
  input  logic [ADDR_W-1:0] req_rs,
  input  logic              req_cmp,
  input  logic              slot_issued,
  input  logic              flush,
  output logic              redir_valid,
  input  logic              redir_ready,
  output logic [ADDR_W-1:0] redir_target,
  output logic              link_valid,
  output logic [ADDR_W-1:0] link_addr
`ifdef TARGET_ALIGN_CHECK_EN
  ,
  output logic              addr_err,
  output logic [ADDR_W-1:0] bad_vaddr
`endif
);

  state_t            state_reg, state_next;
  logic [1:0]        slot_cnt_reg, slot_cnt_next;
  logic [2:0]        slot_inc;
  logic [ADDR_W-1:0] target_reg, link_addr_reg;
  logic              link_valid_reg;
  logic [ADDR_W-1:0] calc_target, target_next;
  logic              calc_taken, go, accept;

  j_target_calc #(
    .ADDR_W(ADDR_W),
    .IMM_W (IMM_W)
  ) u_calc (
    .kind  (req_kind),
    .pc    (req_pc),
    .imm   (req_imm),
    .rs    (req_rs),
    .cmp   (req_cmp),
    .target(calc_target),
    .taken (calc_taken)
  );

  assign req_ready = (state_reg == IDLE);
  assign accept    = req_valid && req_ready && !flush;
  assign slot_inc  = {1'b0, slot_cnt_reg} + 3'd1;

`ifdef TARGET_ALIGN_CHECK_EN
  logic              misaligned;
  logic              addr_err_reg;
  logic [ADDR_W-1:0] bad_vaddr_reg;

  assign misaligned  = is_reg_jump(req_kind) && (req_rs[1:0] != 2'b00);
  assign go          = calc_taken && !misaligned;
  assign target_next = calc_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err_reg  <= 1'b0;
      bad_vaddr_reg <= '0;
    end else begin
      addr_err_reg <= accept && misaligned;
      if (accept && misaligned) bad_vaddr_reg <= req_rs;
    end
  end

  assign addr_err  = addr_err_reg;
  assign bad_vaddr = bad_vaddr_reg;
`else
  // Without the check, register targets are silently word-aligned.
  assign go          = calc_taken;
  assign target_next = is_reg_jump(req_kind) ? {calc_target[ADDR_W-1:2], 2'b00}
                                             : calc_target;
`endif

  always_comb begin
    state_next    = state_reg;
    slot_cnt_next = slot_cnt_reg;
    if (flush) begin
      state_next    = IDLE;
      slot_cnt_next = 2'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept && go) begin
            slot_cnt_next = 2'd0;
            state_next    = (SLOT_CNT > 0) ? WAIT_SLOT : REDIRECT;
          end
        end
        WAIT_SLOT: begin
          if (slot_issued) begin
            if (slot_inc == 3'(SLOT_CNT)) begin
              state_next    = REDIRECT;
              slot_cnt_next = 2'd0;
            end else begin
              slot_cnt_next = slot_inc[1:0];
            end
          end
        end
        REDIRECT: begin
          if (redir_ready) state_next = IDLE;
        end
        default: begin
          state_next    = IDLE;
          slot_cnt_next = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      slot_cnt_reg   <= 2'd0;
      target_reg     <= '0;
      link_valid_reg <= 1'b0;
      link_addr_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      slot_cnt_reg   <= slot_cnt_next;
      link_valid_reg <= accept && is_link(req_kind);
      if (accept && go) target_reg <= target_next;
      if (accept && is_link(req_kind))
        link_addr_reg <= req_pc + ADDR_W'(4 * (SLOT_CNT + 1));
    end
  end

  assign redir_valid  = (state_reg == REDIRECT);
  assign redir_target = target_reg;
  assign link_valid   = link_valid_reg;
  assign link_addr    = link_addr_reg;

endmodule

// File: doc/jump_redirect_unit.md
Name: jump_redirect_unit

Overview:
- Parametrised successor to the combinational J-type target join.
- Accepts one resolved control-transfer request per handshake from decode/issue: J, JAL, JR, JALR or a conditional branch.
- Computes the target, tracks a configurable number of delay-slot instructions, then issues one registered redirect to fetch over a valid/ready handshake.
- Produces the link address for JAL/JALR.

Parameters:
- ADDR_W, 32, address/PC width; must satisfy ADDR_W >= IMM_W+2.
- IMM_W, 26, jump-index width; SLOT_W = ADDR_W-IMM_W-2 is a derived localparam (4 at defaults).
- SLOT_CNT, 1, delay-slot instructions to retire before redirect; 0..3; 0 means no delay slot.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; 1 iff state==IDLE.
- req_kind  in  3  0=J 1=JAL 2=JR 3=JALR 4=BR; 5-7 reserved.
- req_pc  in  ADDR_W  PC of the transfer instruction.
- req_imm  in  IMM_W  instruction index field; BR uses [15:0].
- req_rs  in  ADDR_W  register value for JR/JALR.
- req_cmp  in  1  branch condition result (BR taken iff 1).
- slot_issued  in  1  one delay-slot instruction left decode this cycle.
- flush  in  1  pipeline flush (exception/ERET).
- redir_valid  out  1  redirect pending to fetch.
- redir_ready  in  1  fetch accepts redirect.
- redir_target  out  ADDR_W  redirect address, stable while redir_valid.
- link_valid  out  1  one-cycle pulse, link address valid.
- link_addr  out  ADDR_W  return address.

Behaviour:

Reset:
- State IDLE; slot counter 0.
- redir_valid=0, redir_target=0, link_valid=0, link_addr=0.
- req_ready=1 once rst_n is high.

Target, computed in the accept cycle and registered; pc4 = req_pc+4, modulo 2^ADDR_W:
- J/JAL: {pc4[ADDR_W-1 -: SLOT_W], req_imm, 2'b00}.
- BR: pc4 + (sign_extend(req_imm[15:0]) << 2), wrapping modulo 2^ADDR_W.
- JR/JALR: req_rs.

Taken:
- J, JAL, JR and JALR are always taken.
- BR is taken iff req_cmp=1.
- Reserved kinds are never taken and produce no link.

Link (JAL/JALR only):
- link_addr = req_pc + 4*(SLOT_CNT+1), registered.
- link_valid pulses the cycle after accept, including when a flush arrives in that cycle.

State machine:
- IDLE:
  - Accept on req_valid&&req_ready.
  - Not taken: remain in IDLE.
  - Taken with SLOT_CNT>0: go to WAIT_SLOT, counter=0.
  - Taken with SLOT_CNT=0: go to REDIRECT.
- WAIT_SLOT:
  - Each slot_issued increments the counter.
  - When the increment reaches SLOT_CNT, go to REDIRECT next cycle.
  - slot_issued in the accept cycle itself is ignored, since that instruction precedes the transfer.
- REDIRECT:
  - redir_valid=1 and redir_target is held.
  - On redir_ready: go to IDLE; redir_valid=0 next cycle.
  - No new request is accepted in the handshake cycle; minimum spacing between accepts is 2 cycles.
  - slot_issued in this state is ignored.

Flush:
- Highest priority, any state.
- Next state is IDLE, counter cleared, redir_valid deasserts next cycle.
- A request offered in the same cycle as flush is not accepted.

Reset mid-operation:
- Asynchronous return to the reset values.
- A pending redirect is lost.

Optional Feature:
- Macro: TARGET_ALIGN_CHECK_EN.
- Defined:
  - A JR/JALR with req_rs[1:0]!=0 produces no redirect and stays in IDLE.
  - Adds outputs addr_err (one-cycle pulse the cycle after accept) and bad_vaddr (ADDR_W, holds req_rs).
  - The link is still produced.
- Undefined:
  - Those ports are absent.
  - redir_target[1:0] is forced to 2'b00 for JR/JALR.

Decomposition:
- Shared header jump_defs: KIND_J/JAL/JR/JALR/BR encodings, state encodings IDLE/WAIT_SLOT/REDIRECT.
- One combinational sub-module, j_target_calc, parametrised by ADDR_W/IMM_W. It takes kind, pc, imm, rs, cmp and produces target and taken.
- The FSM, counter and output registers stay in the top module.

Test Plan:
- J with req_pc=0x40001000, req_imm=0x0000100, SLOT_CNT=1: one slot_issued, redir_ready=1 -> redir_target=0x40000400, asserted exactly one cycle after slot_issued, no link_valid.
- JAL with req_pc=0x00400020 -> link_valid pulse with link_addr=0x00400028; redirect after the slot.
- BR with req_pc=0x00000010, imm16=0xFFFF, req_cmp=1 -> target 0x00000010. BR with req_cmp=0 -> no redirect, req_ready stays 1.
- Wrap: BR with req_pc=0xFFFFFFF8, imm16=0x0001 -> target 0x00000000. J at req_pc=0xFFFFFFFC -> upper nibble from pc4=0x0, so 0x0XXXXXXX.
- Backpressure: hold redir_ready=0 for 5 cycles -> redir_valid and target stable, req_ready=0. Flush in the 3rd cycle -> redir_valid=0 next cycle, IDLE.
- SLOT_CNT=0 JR with req_rs=0x80000003:
  - Without TARGET_ALIGN_CHECK_EN -> redirect next cycle to 0x80000000.
  - With TARGET_ALIGN_CHECK_EN -> addr_err pulse with bad_vaddr=0x80000003 and no redirect.
